// File: rtl/window_generator.sv
// Sliding-window generator: raster pixel stream in, flattened KxK window out.
// Holds KERNEL_SIZE-1 line buffers plus a KxK window register, with
// valid/ready backpressure on both sides.
// Optional feature: define WINDOW_FRAME_DONE_EN to add the frame_done pulse
// output, asserted when the last window of a frame is consumed.
module window_generator #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 5,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [DATA_WIDTH-1:0]                         pixel_in,
  input  logic                                          pixel_valid,
  output logic                                          pixel_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0] window_out,
  output logic                                          window_valid,
  input  logic                                          window_ready
`ifdef WINDOW_FRAME_DONE_EN
  ,
  output logic                                          frame_done
`endif
);

  localparam int K  = KERNEL_SIZE;
  localparam int WW = K * K * DATA_WIDTH;
  localparam int CW = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
  localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

  localparam logic [CW-1:0] COL_LAST      = CW'(IMAGE_WIDTH - 1);
  localparam logic [CW-1:0] COL_FIRST_WIN = CW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST      = RW'(IMAGE_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_FIRST_WIN = RW'(K - 1);
  localparam logic [RW-1:0] ROW_FILL_LAST = RW'(K - 2);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] STALL = 2'd3;

  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [1:0]            state_q, state_d;
  logic [WW-1:0]         win_q, win_d;
  logic                  wvld_q, wvld_d;
  logic [DATA_WIDTH-1:0] lb_q [K-1][IMAGE_WIDTH];
  logic [DATA_WIDTH-1:0] col_new [K];

  logic accept, complete, last_px;

  // Handshake: a pending, unconsumed window blocks input; nothing is taken in reset.
  always_comb begin
    pixel_ready = !reset && !(wvld_q && !window_ready);
    accept      = pixel_valid && pixel_ready;
    complete    = accept && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);
    last_px     = (col_q == COL_LAST) && (row_q == ROW_LAST);
  end

  // New column entering the window: buffered rows oldest first, then the live pixel.
  always_comb begin
    for (int k = 0; k < K - 1; k++) col_new[k] = lb_q[k][col_q];
    col_new[K-1] = pixel_in;
  end

  // Window register shifts left one column per accepted pixel.
  always_comb begin
    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          if (c < K - 1)
            win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[(r*K+c+1)*DATA_WIDTH +: DATA_WIDTH];
          else
            win_d[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = col_new[r];
        end
      end
    end
  end

  // Raster counters point at the next pixel to be accepted.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Valid is set by a completing accept, else cleared by consumption.
  always_comb begin
    wvld_d = wvld_q;
    if (complete)          wvld_d = 1'b1;
    else if (window_ready) wvld_d = 1'b0;
  end

  // Frame sequencing; K is at least 2, so the first accept always starts FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = FILL;
      FILL:  if (accept && row_q == ROW_FILL_LAST && col_q == COL_LAST) state_d = RUN;
      RUN: begin
        if (wvld_q && !window_ready) state_d = STALL;
        else if (accept && last_px)  state_d = IDLE;
      end
      STALL: if (window_ready) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Control and window state, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      state_q <= IDLE;
      win_q   <= '0;
      wvld_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      state_q <= state_d;
      win_q   <= win_d;
      wvld_q  <= wvld_d;
    end
  end

  // Line buffers rotate up one row at the accepted column; never cleared.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < K - 1; k++) lb_q[k][col_q] <= col_new[k+1];
    end
  end

  assign window_out   = win_q;
  assign window_valid = wvld_q;

`ifdef WINDOW_FRAME_DONE_EN
  logic last_win_q, last_win_d;
  logic fd_q, fd_d;

  // Track whether the pending window is the final one of its frame.
  always_comb begin
    last_win_d = last_win_q;
    if (complete)          last_win_d = last_px;
    else if (window_ready) last_win_d = 1'b0;
    fd_d = wvld_q && window_ready && last_win_q;
  end

  // Frame-done pulse register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_win_q <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      last_win_q <= last_win_d;
      fd_q       <= fd_d;
    end
  end

  assign frame_done = fd_q;
`endif

endmodule

// File: tb/tb_window_generator.sv
// Scoreboard bench for window_generator: expected windows are built from a
// full-frame image copy when a completing pixel is accepted, and compared
// when the DUT's window is consumed.
module tb_window_generator;
  localparam int DW   = 16;
  localparam int K    = 5;
  localparam int W    = 28;
  localparam int H    = 28;
  localparam int WW   = K * K * DW;
  localparam int NWIN = (H - K + 1) * (W - K + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] pixel_in;
  logic          pixel_valid, pixel_ready;
  logic [WW-1:0] window_out;
  logic          window_valid, window_ready;
`ifdef WINDOW_FRAME_DONE_EN
  logic frame_done;
  logic fd_exp    = 1'b0;
  int   fd_pulses = 0;
`endif

  window_generator #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk          (clk),
    .reset        (reset),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .pixel_ready  (pixel_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
    .window_ready (window_ready)
`ifdef WINDOW_FRAME_DONE_EN
    ,
    .frame_done   (frame_done)
`endif
  );

  always #5 clk = ~clk;

  int            n_chk  = 0;
  int            n_pass = 0;
  logic [WW-1:0] exp_q [$];
  logic [DW-1:0] img [H][W];

  task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] pix(input int mode, input int r, input int c);
    return (mode == 0) ? DW'(r * W + c) : 16'h0200;
  endfunction

  // mode 0 ramp / 1 constant; gap/rdy in percent low; bp stalls the first
  // window 5 cycles; rst_row >= 0 abandons the frame at that row.
  task automatic run_frame(input int mode, input int gap_pct, input int rdy_pct,
                           input bit bp_first, input int rst_row);
    int idx = 0, got = 0, cyc = 0, bp_left = 0, r, c;
    bit seen = 0, first_push = 0, lat_pending = 0, done = 0;
    logic [WW-1:0] held = '0, e, ew;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 20000) begin
        chk("timeout", WW'(got), WW'(NWIN));
        break;
      end
      if (rst_row >= 0 && idx == rst_row * W) begin
        reset = 1'b1; pixel_valid = 1'b0; window_ready = 1'b1;
        #1 chk("rst_mid_prdy", WW'(pixel_ready), WW'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_wvld", WW'(window_valid), WW'(0));
        chk("rst_mid_wout", window_out, WW'(0));
        chk("rst_mid_prdy_after", WW'(pixel_ready), WW'(1));
`ifdef WINDOW_FRAME_DONE_EN
        chk("rst_mid_fd", WW'(frame_done), WW'(0));
        fd_exp = 1'b0;
`endif
        exp_q.delete();
        break;
      end
      if (!seen && bp_first && window_valid) begin
        seen = 1; bp_left = 5; held = window_out;
      end
      pixel_valid  = (idx < W * H) && ($urandom_range(99) >= gap_pct);
      pixel_in     = pixel_valid ? pix(mode, idx / W, idx % W) : DW'($urandom);
      window_ready = (bp_left > 0) ? 1'b0 : ($urandom_range(99) >= rdy_pct);
      #1;
`ifdef WINDOW_FRAME_DONE_EN
      chk("frame_done", WW'(frame_done), WW'(fd_exp));
      if (frame_done) fd_pulses++;
      fd_exp = 1'b0;
`endif
      if (bp_left > 0) begin
        chk("bp_prdy", WW'(pixel_ready), WW'(0));
        chk("bp_hold", window_out, held);
        bp_left--;
      end
      if (lat_pending) begin
        chk("first_lat", WW'(window_valid), WW'(1));
        lat_pending = 0;
      end
      if (window_valid && window_ready) begin
        if (exp_q.size() == 0) chk("unexpected_win", WW'(exp_q.size()), WW'(1));
        else begin
          e = exp_q.pop_front();
          chk("win", window_out, e);
          if (mode == 0 && got == 0) begin
            chk("ramp_first_00", WW'(window_out[DW-1:0]), WW'(0));
            chk("ramp_first_44", WW'(window_out[WW-1 -: DW]), WW'(116));
          end
          if (mode == 0 && got == NWIN - 1) begin
            chk("ramp_last_00", WW'(window_out[DW-1:0]), WW'(667));
            chk("ramp_last_44", WW'(window_out[WW-1 -: DW]), WW'(783));
          end
          got++;
`ifdef WINDOW_FRAME_DONE_EN
          if (got == NWIN) fd_exp = 1'b1;
`endif
        end
      end
      if (pixel_valid && pixel_ready) begin
        r = idx / W; c = idx % W;
        img[r][c] = pixel_in;
        if (r >= K - 1 && c >= K - 1) begin
          for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
              ew[(i*K+j)*DW +: DW] = img[r-K+1+i][c-K+1+j];
          exp_q.push_back(ew);
          if (!first_push) begin
            first_push = 1;
            chk("pre_first_wvld", WW'(window_valid), WW'(0));
            lat_pending = 1;
          end
        end
        idx++;
      end
      if (idx == W * H && exp_q.size() == 0) done = 1;
    end
    if (rst_row < 0) chk("win_count", WW'(got), WW'(NWIN));
  endtask

  initial begin
    reset = 1'b1; pixel_valid = 1'b0; window_ready = 1'b0; pixel_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_prdy", WW'(pixel_ready), WW'(0));
    chk("rst_wvld", WW'(window_valid), WW'(0));
    chk("rst_wout", window_out, WW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1 chk("post_rst_prdy", WW'(pixel_ready), WW'(1));

    run_frame(0, 0, 0, 0, -1);    // ramp
    run_frame(1, 0, 0, 0, -1);    // constant 0x0200
    run_frame(0, 0, 0, 1, -1);    // backpressure on first window
    run_frame(0, 30, 30, 0, -1);  // gapped input and random ready
    run_frame(0, 0, 0, 0, 10);    // reset at row 10
    run_frame(0, 0, 0, 0, -1);    // fresh ramp after reset
    run_frame(0, 0, 0, 0, -1);    // back-to-back with the previous frame

    @(negedge clk);
    pixel_valid = 1'b0; window_ready = 1'b1;
    #1;
`ifdef WINDOW_FRAME_DONE_EN
    chk("frame_done_tail", WW'(frame_done), WW'(fd_exp));
    if (frame_done) fd_pulses++;
    chk("frame_done_pulses", WW'(fd_pulses), WW'(6));
`endif
    chk("tail_wvld", WW'(window_valid), WW'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
